// File: rtl/serv_wb_mem_responder.sv
// Shared word-addressed memory answering the SERV ibus and dbus Wishbone ports.
// Each port runs its own IDLE/WAIT/ACK sequencer; the memory is accessed on the edge entering ACK.

module serv_wb_port #(
  parameter int AW  = 10,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic [31:0]   adr_i,
  input  logic [31:0]   dat_i,
  input  logic [3:0]    sel_i,
  input  logic          we_i,
  input  logic          cyc_i,
  input  logic [31:0]   rd_word_i,
  output logic          access_o,
  output logic [AW-1:0] idx_o,
  output logic [31:0]   dat_o,
  output logic [3:0]    sel_o,
  output logic          we_o,
  output logic          in_range_o,
  output logic          ack_o,
  output logic [31:0]   rdt_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic [31:0] rdt_q, rdt_d;
  logic        unused_adr_lsb;

  assign unused_adr_lsb = ^adr_i[1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    access_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cyc_i) begin
          adr_d = adr_i[31:2];
          dat_d = dat_i;
          sel_d = sel_i;
          we_d  = we_i;
          cnt_d = 2'(LAT - 1);
          if (LAT == 1) begin
            state_d  = S_ACK;
            access_o = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 2'd1) begin
          state_d  = S_ACK;
          access_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset aborts everything, including a write that would land on this edge.
    if (rst_i) begin
      state_d  = S_IDLE;
      access_o = 1'b0;
    end
  end

  // The _d request fields equal the request being served whenever access_o is high.
  assign idx_o      = adr_d[AW-1:0];
  assign in_range_o = (adr_d[29:AW] == '0);
  assign dat_o      = dat_d;
  assign sel_o      = sel_d;
  assign we_o       = we_d;

  assign ack_d = access_o;
  assign rdt_d = (access_o && !we_d && in_range_o) ? rd_word_i : 32'd0;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      adr_q   <= 30'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
    end
  end

  assign ack_o = ack_q;
  assign rdt_o = rdt_q;
endmodule

module serv_wb_mem_responder #(
  parameter int AW   = 10,
  parameter int ILAT = 1,
  parameter int DLAT = 2
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack
);
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] i_idx, d_idx;
  logic [31:0]   d_dat;
  logic [3:0]    d_sel;
  logic          d_we, d_access, d_in_range;
  logic          unused_i_access, unused_i_we, unused_i_in_range;
  logic [31:0]   unused_i_dat;
  logic [3:0]    unused_i_sel;

  serv_wb_port #(.AW(AW), .LAT(ILAT)) u_ibus (
    .clk        (clk),
    .rst_i      (i_rst),
    .adr_i      (i_ibus_adr),
    .dat_i      (32'd0),
    .sel_i      (4'd0),
    .we_i       (1'b0),
    .cyc_i      (i_ibus_cyc),
    .rd_word_i  (mem[i_idx]),
    .access_o   (unused_i_access),
    .idx_o      (i_idx),
    .dat_o      (unused_i_dat),
    .sel_o      (unused_i_sel),
    .we_o       (unused_i_we),
    .in_range_o (unused_i_in_range),
    .ack_o      (o_ibus_ack),
    .rdt_o      (o_ibus_rdt)
  );

  serv_wb_port #(.AW(AW), .LAT(DLAT)) u_dbus (
    .clk        (clk),
    .rst_i      (i_rst),
    .adr_i      (i_dbus_adr),
    .dat_i      (i_dbus_dat),
    .sel_i      (i_dbus_sel),
    .we_i       (i_dbus_we),
    .cyc_i      (i_dbus_cyc),
    .rd_word_i  (mem[d_idx]),
    .access_o   (d_access),
    .idx_o      (d_idx),
    .dat_o      (d_dat),
    .sel_o      (d_sel),
    .we_o       (d_we),
    .in_range_o (d_in_range),
    .ack_o      (o_dbus_ack),
    .rdt_o      (o_dbus_rdt)
  );

  // Non-blocking update means an ibus read on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (d_access && d_we && d_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (d_sel[b]) mem[d_idx][8*b +: 8] <= d_dat[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_serv_wb_mem_responder.sv
// Directed and randomized checks of serv_wb_mem_responder with ILAT=1, DLAT=2, AW=10.

module tb_serv_wb_mem_responder;
  localparam int AW   = 10;
  localparam int ILAT = 1;
  localparam int DLAT = 2;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  logic [31:0] ibus_exp_q[$];
  logic [31:0] dbus_exp_q[$];
  logic [31:0] model [8];
  int tests = 0;
  int fails = 0;

  serv_wb_mem_responder #(.AW(AW), .ILAT(ILAT), .DLAT(DLAT)) u_dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_dat (i_dbus_dat),
    .i_dbus_sel (i_dbus_sel),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_cyc (i_dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transaction on either port; expected rdt goes through the scoreboard.
  task automatic xfer(input bit dport, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we, input logic [31:0] exp);
    int          lat;
    bit          got;
    logic [31:0] rdt;
    logic [31:0] e;
    string       tag;
    tag = dport ? "d" : "i";
    if (dport) dbus_exp_q.push_back(exp);
    else       ibus_exp_q.push_back(exp);
    @(negedge clk);
    if (dport) begin
      i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel; i_dbus_we = we; i_dbus_cyc = 1'b1;
    end else begin
      i_ibus_adr = adr; i_ibus_cyc = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      step();
      lat++;
      got = dport ? o_dbus_ack : o_ibus_ack;
    end
    rdt = dport ? o_dbus_rdt : o_ibus_rdt;
    if (dport) e = dbus_exp_q.pop_front();
    else       e = ibus_exp_q.pop_front();
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), dport ? 32'(DLAT) : 32'(ILAT));
    check({tag, "_rdt"}, rdt, e);
    if (dport) i_dbus_cyc = 1'b0;
    else       i_ibus_cyc = 1'b0;
    step();
    check({tag, "_ack_drop"}, 32'(dport ? o_dbus_ack : o_ibus_ack), 32'd0);
    check({tag, "_rdt_drop"}, dport ? o_dbus_rdt : o_ibus_rdt, 32'd0);
  endtask

  initial begin
    int          w;
    int          op;
    logic [31:0] d;
    logic [3:0]  s;

    // reset with both requests asserted
    i_rst = 1'b1;
    i_ibus_adr = 32'h10; i_ibus_cyc = 1'b1;
    i_dbus_adr = 32'h20; i_dbus_dat = 32'hdeadbeef; i_dbus_sel = 4'hf; i_dbus_we = 1'b1;
    i_dbus_cyc = 1'b1;
    repeat (3) begin
      step();
      check("rst_i_ack", 32'(o_ibus_ack), 32'd0);
      check("rst_d_ack", 32'(o_dbus_ack), 32'd0);
      check("rst_i_rdt", o_ibus_rdt, 32'd0);
      check("rst_d_rdt", o_dbus_rdt, 32'd0);
    end
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    step();
    i_rst = 1'b0;

    // preload and fetch
    xfer(1'b1, 32'h10, 32'h00a00093, 4'hf, 1'b1, 32'd0);
    xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 32'h00a00093);
    xfer(1'b0, 32'h13, 32'd0, 4'h0, 1'b0, 32'h00a00093);

    // partial write, then read
    xfer(1'b1, 32'h20, 32'h11223344, 4'hf, 1'b1, 32'd0);
    xfer(1'b1, 32'h20, 32'haabbccdd, 4'b0101, 1'b1, 32'd0);
    xfer(1'b1, 32'h20, 32'd0, 4'h0, 1'b0, 32'h11bb33dd);
    // sel=0 write acks but changes nothing
    xfer(1'b1, 32'h20, 32'h0, 4'h0, 1'b1, 32'd0);
    xfer(1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 32'h11bb33dd);

    // abort after one cycle of cyc
    @(negedge clk);
    i_dbus_adr = 32'h20; i_dbus_dat = 32'h0; i_dbus_sel = 4'hf; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    step();
    i_dbus_cyc = 1'b0;
    repeat (4) begin
      step();
      check("abort_no_ack", 32'(o_dbus_ack), 32'd0);
    end
    xfer(1'b1, 32'h20, 32'd0, 4'h0, 1'b0, 32'h11bb33dd);

    // reset on the edge that would perform the write
    @(negedge clk);
    i_dbus_adr = 32'h20; i_dbus_dat = 32'h0; i_dbus_sel = 4'hf; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    step();
    i_rst = 1'b1;
    step();
    check("midrst_no_ack", 32'(o_dbus_ack), 32'd0);
    i_rst = 1'b0;
    i_dbus_cyc = 1'b0;
    step();
    check("midrst_no_ack2", 32'(o_dbus_ack), 32'd0);
    xfer(1'b1, 32'h20, 32'd0, 4'h0, 1'b0, 32'h11bb33dd);

    // collision: ibus read and dbus write of 0x40 on the same edge
    xfer(1'b1, 32'h40, 32'h0, 4'hf, 1'b1, 32'd0);
    ibus_exp_q.push_back(32'd0);
    dbus_exp_q.push_back(32'd0);
    @(negedge clk);
    i_dbus_adr = 32'h40; i_dbus_dat = 32'hffffffff; i_dbus_sel = 4'hf; i_dbus_we = 1'b1;
    i_dbus_cyc = 1'b1;
    step();
    check("coll_early_ack", {30'd0, o_ibus_ack, o_dbus_ack}, 32'd0);
    i_ibus_adr = 32'h40;
    i_ibus_cyc = 1'b1;
    step();
    check("coll_i_ack", 32'(o_ibus_ack), 32'd1);
    check("coll_d_ack", 32'(o_dbus_ack), 32'd1);
    check("coll_i_rdt", o_ibus_rdt, ibus_exp_q.pop_front());
    check("coll_d_rdt", o_dbus_rdt, dbus_exp_q.pop_front());
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    step();
    xfer(1'b0, 32'h40, 32'd0, 4'h0, 1'b0, 32'hffffffff);

    // out of range: 0x00010000 aliases word 0 in the low bits only
    xfer(1'b1, 32'h0, 32'h12345678, 4'hf, 1'b1, 32'd0);
    xfer(1'b1, 32'h00010000, 32'hffffffff, 4'hf, 1'b1, 32'd0);
    xfer(1'b0, 32'h0, 32'd0, 4'h0, 1'b0, 32'h12345678);
    xfer(1'b0, 32'h00010000, 32'd0, 4'h0, 1'b0, 32'd0);
    xfer(1'b1, 32'h00010000, 32'd0, 4'h0, 1'b0, 32'd0);
    xfer(1'b1, 32'h80000010, 32'd0, 4'h0, 1'b0, 32'd0);
    xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 32'h00a00093);

    // randomized traffic over eight words at 0x100
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      xfer(1'b1, 32'h100 + 32'(4 * i), model[i], 4'hf, 1'b1, 32'd0);
    end
    for (int n = 0; n < 24; n++) begin
      w  = $urandom_range(0, 7);
      op = $urandom_range(0, 2);
      if (op == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) begin
          if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
        end
        xfer(1'b1, 32'h100 + 32'(4 * w), d, s, 1'b1, 32'd0);
      end else begin
        xfer(op == 2, 32'h100 + 32'(4 * w) + 32'($urandom_range(0, 3)), 32'd0, 4'h0, 1'b0,
             model[w]);
      end
    end

    check("queues_empty", 32'(ibus_exp_q.size() + dbus_exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
